// File: rtl/if_id_reg.sv
// IF/ID pipeline register: realigns the one-cycle instruction-memory latency with the
// fetch PC, and adds a one-entry skid buffer for stalls and flush-to-NOP for taken jumps.
module if_id_reg #(
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int unsigned HOLD_W    = 3
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [31:0]       fetch_pc_i,
   input  logic [31:0]       fetch_instr_i,
   input  logic              jump_flag_i,
   input  logic [HOLD_W-1:0] hold_flag_i,
   output logic [31:0]       id_pc_o,
   output logic [31:0]       id_instr_o,
   output logic              id_valid_o
);

   logic [31:0] pc_q;
   logic        vq;
   logic [31:0] skid_pc;
   logic [31:0] skid_instr;
   logic        skid_v;
   logic        stall;

   // Hold codes 2 (IF/ID) and 3 (ID) both freeze this stage
   assign stall = (hold_flag_i >= HOLD_W'(2));

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pc_q       <= RESET_PC;
         vq         <= 1'b0;
         skid_pc    <= RESET_PC;
         skid_instr <= NOP_INSTR;
         skid_v     <= 1'b0;
         id_pc_o    <= RESET_PC;
         id_instr_o <= NOP_INSTR;
         id_valid_o <= 1'b0;
      end else begin
         // (pc_q, fetch_instr_i) forms the candidate; a jump marks this cycle's fetch wrong-path
         pc_q <= fetch_pc_i;
         vq   <= ~jump_flag_i;

         if (jump_flag_i) begin
            id_valid_o <= 1'b0;
            id_instr_o <= NOP_INSTR;
            skid_v     <= 1'b0;
         end else if (stall) begin
            // Only the first live candidate is parked; later ones are re-reads of the held PC
            if (vq && !skid_v) begin
               skid_pc    <= pc_q;
               skid_instr <= fetch_instr_i;
               skid_v     <= 1'b1;
            end
         end else if (skid_v) begin
            id_pc_o    <= skid_pc;
            id_instr_o <= skid_instr;
            id_valid_o <= 1'b1;
            skid_v     <= 1'b0;
         end else if (vq) begin
            id_pc_o    <= pc_q;
            id_instr_o <= fetch_instr_i;
            id_valid_o <= 1'b1;
         end else begin
            id_valid_o <= 1'b0;
            id_instr_o <= NOP_INSTR;
         end
      end
   end

endmodule
